id_ex_pipe_stage: RTL and testbench
===================================

// Module: id_ex_pipe_stage
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. Captures decoded operands,
//  register addresses and control from ID each cycle, presents them to EX, the forwarding unit
//  (ex_rs_addr_o/ex_rt_addr_o) and EX/MEM. Inserts a one-cycle bubble on load-use, flushes on
//  taken branch, freezes on a memory stall, and counts lost cycles.
// PARAMETERS
//  DATA_W  32  operand/immediate width
//  ADDR_W  5   register-address width
//  CNT_W   16  width of each stall/flush counter (saturating)
// PORTS
//  clk_i              in   1       clock, rising edge
//  rst_i              in   1       asynchronous, active-low reset
//  mem_stall_i        in   1       global freeze from memory stage
//  flush_i            in   1       taken branch/jump: discard ID instruction
//  id_rs_addr_i       in   ADDR_W  RS address from decode
//  id_rt_addr_i       in   ADDR_W  RT address from decode
//  id_rd_addr_i       in   ADDR_W  RD address from decode
//  id_uses_rt_i       in   1       ID instruction reads RT as a source
//  id_rs_data_i       in   DATA_W  register-file RS data
//  id_rt_data_i       in   DATA_W  register-file RT data
//  id_imm_i           in   DATA_W  sign-extended immediate
//  id_ctrl_i          in   8       {regwrite,memtoreg,memread,memwrite,regdst,alusrc,aluop[1:0]}
//  ex_valid_o         out  1       EX holds a real instruction
//  ex_rs_addr_o       out  ADDR_W  registered RS address (to forwarding unit)
//  ex_rt_addr_o       out  ADDR_W  registered RT address (to forwarding unit)
//  ex_wb_addr_o       out  ADDR_W  destination: regdst ? rd : rt, resolved at capture
//  ex_rs_data_o       out  DATA_W  registered RS data
//  ex_rt_data_o       out  DATA_W  registered RT data
//  ex_imm_o           out  DATA_W  registered immediate
//  ex_ctrl_o          out  8       registered control, same packing as id_ctrl_i
//  pc_write_o         out  1       PC may advance (combinational)
//  ifid_write_o       out  1       IF/ID may load (combinational)
//  stall_cnt_o        out  CNT_W   cycles lost to load-use bubbles
//  flush_cnt_o        out  CNT_W   flushes taken
// BEHAVIOUR
//  - Reset (rst_i=0, async): all ex_* outputs, ex_valid_o and both counters = 0. pc_write_o and
//    ifid_write_o = 1 while reset is asserted and after release. Reset mid-stall drops the stall.
//  - load_use = ex_valid_o & ex_ctrl_o[memread] & (ex_rt_addr_o!=0) & ((ex_rt_addr_o==id_rs_addr_i)
//    | (id_uses_rt_i & ex_rt_addr_o==id_rt_addr_i)). Combinational from registered state.
//  - Per-edge action, strict priority:
//    1 mem_stall_i=1: hold every register and counter; pc_write_o=ifid_write_o=0.
//    2 flush_i=1: load bubble; pc_write_o=1, ifid_write_o=1; flush_cnt_o+1. Flush overrides load_use.
//    3 load_use=1: load bubble; pc_write_o=ifid_write_o=0; stall_cnt_o+1.
//    4 else: capture all id_* fields, ex_valid_o=1, ex_wb_addr_o=regdst?rd:rt; writes enabled.
//  - Bubble: ex_valid_o=0, ex_ctrl_o=0, all address/data/imm fields=0. An inserted bubble never
//    triggers load_use, so a load-use stall lasts exactly one cycle; the held ID instruction is
//    captured on the following edge.
//  - Capture latency: 1 cycle ID -> EX. Control and write-enable outputs are never X post-reset.
//  - Counters saturate at 2^CNT_W-1; no wrap.
//  - RT==0 destination never causes a stall (register $0 is hard-wired).
// TESTING
//  1 Reset: hold rst_i=0 with random inputs -> all outputs 0 except pc_write_o=ifid_write_o=1;
//    release -> first edge captures id_* with ex_valid_o=1.
//  2 lw $2 then add $3,$2,$4 -> one cycle pc_write_o=0, ifid_write_o=0, ex_ctrl_o=0,
//    ex_valid_o=0; next edge add captured with ex_rs_addr_o=2; stall_cnt_o=1.
//  3 lw $0 followed by use of $0; and lw $5 followed by sw using $5 only as RS with id_uses_rt_i=0
//    and id_rt_addr_i=5 -> stall only in second case when RS=5, never for $0.
//  4 Load-use coinciding with flush_i=1 -> bubble, pc_write_o=1, flush_cnt_o+1, stall_cnt_o unchanged.
//  5 mem_stall_i=1 for 3 cycles during a load-use -> all outputs frozen, counters frozen; on
//    release the single bubble is inserted once.
//  6 With CNT_W=2, force 5 load-use stalls -> stall_cnt_o saturates at 3.

Source files
------------

// File: rtl/id_ex_pipe_stage.sv
// ----------------------------------------------------------------------------
// id_ex_pipe_stage
//
// ID/EX pipeline register with integrated load-use hazard detection.
// Each cycle it captures the decoded operands, register addresses and control
// word from ID and presents them to EX, to the forwarding unit and onward to
// EX/MEM. The stage inserts a one-cycle bubble on a load-use hazard, flushes
// the ID instruction on a taken branch, freezes on a memory stall, and counts
// the cycles lost to bubbles and flushes.
//
// Ports
//   clk_i, rst_i           clock (rising edge), async active-low reset
//   mem_stall_i            global freeze from the memory stage
//   flush_i                taken branch/jump: discard the ID instruction
//   id_rs/rt/rd_addr_i     register addresses from decode
//   id_uses_rt_i           ID instruction reads RT as a source
//   id_rs/rt_data_i        register-file read data
//   id_imm_i               sign-extended immediate
//   id_ctrl_i              {regwrite,memtoreg,memread,memwrite,regdst,alusrc,aluop[1:0]}
//   ex_valid_o             EX holds a real instruction
//   ex_rs/rt_addr_o        registered source addresses (forwarding unit)
//   ex_wb_addr_o           destination, regdst ? rd : rt, resolved at capture
//   ex_rs/rt_data_o        registered operands
//   ex_imm_o               registered immediate
//   ex_ctrl_o              registered control, same packing as id_ctrl_i
//   pc_write_o             PC may advance (combinational)
//   ifid_write_o           IF/ID may load (combinational)
//   stall_cnt_o            saturating count of load-use bubbles
//   flush_cnt_o            saturating count of flushes taken
// ----------------------------------------------------------------------------
module id_ex_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] id_rs_addr_i,
    input  logic [ADDR_W-1:0] id_rt_addr_i,
    input  logic [ADDR_W-1:0] id_rd_addr_i,
    input  logic              id_uses_rt_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [7:0]        id_ctrl_i,
    output logic              ex_valid_o,
    output logic [ADDR_W-1:0] ex_rs_addr_o,
    output logic [ADDR_W-1:0] ex_rt_addr_o,
    output logic [ADDR_W-1:0] ex_wb_addr_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [7:0]        ex_ctrl_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    // Bit positions inside the control word.
    localparam int C_REGDST  = 3;
    localparam int C_MEMREAD = 5;

    logic              r_valid;
    logic [ADDR_W-1:0] r_rs_addr;
    logic [ADDR_W-1:0] r_rt_addr;
    logic [ADDR_W-1:0] r_wb_addr;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [7:0]        r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic              w_rt_hit_rs;
    logic              w_rt_hit_rt;
    logic              w_load_use;
    logic              w_do_flush;
    logic              w_do_stall;
    logic              w_bubble;
    logic              w_capture;
    logic              w_write_en;
    logic [ADDR_W-1:0] w_wb_addr;

    // ------------------------------------------------------------------------
    // Hazard detection, purely from registered EX state and the ID fields.
    // A bubble has r_valid=0 and r_ctrl=0, so it can never raise load_use;
    // this is what limits a load-use stall to exactly one cycle.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rt_hit_rs = (r_rt_addr == id_rs_addr_i);
        w_rt_hit_rt = id_uses_rt_i & (r_rt_addr == id_rt_addr_i);
        w_load_use  = r_valid & r_ctrl[C_MEMREAD] & (r_rt_addr != '0)
                    & (w_rt_hit_rs | w_rt_hit_rt);
    end

    // ------------------------------------------------------------------------
    // Per-edge action in strict priority: freeze > flush > load-use > capture.
    // ------------------------------------------------------------------------
    always_comb begin
        w_do_flush = ~mem_stall_i & flush_i;
        w_do_stall = ~mem_stall_i & ~flush_i & w_load_use;
        w_bubble   = w_do_flush | w_do_stall;
        w_capture  = ~mem_stall_i & ~flush_i & ~w_load_use;
        w_wb_addr  = id_ctrl_i[C_REGDST] ? id_rd_addr_i : id_rt_addr_i;
    end

    // Front-end write enables. Forced high during reset so the PC and IF/ID
    // never see a spurious hold while the pipe is being cleared; a flush
    // re-steers the front end even when a load-use hazard is present.
    always_comb begin
        w_write_en   = ~rst_i | (~mem_stall_i & (flush_i | ~w_load_use));
        pc_write_o   = w_write_en;
        ifid_write_o = w_write_en;
    end

    // ------------------------------------------------------------------------
    // Pipeline register. Under mem_stall_i nothing is written (implicit hold).
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid   <= 1'b0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_wb_addr <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= '0;
        end else if (w_bubble) begin
            r_valid   <= 1'b0;
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_wb_addr <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= '0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_rs_addr <= id_rs_addr_i;
            r_rt_addr <= id_rt_addr_i;
            r_wb_addr <= w_wb_addr;
            r_rs_data <= id_rs_data_i;
            r_rt_data <= id_rt_data_i;
            r_imm     <= id_imm_i;
            r_ctrl    <= id_ctrl_i;
        end
    end

    // ------------------------------------------------------------------------
    // Lost-cycle counters, saturating at all-ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_do_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (w_do_flush && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign ex_valid_o   = r_valid;
    assign ex_rs_addr_o = r_rs_addr;
    assign ex_rt_addr_o = r_rt_addr;
    assign ex_wb_addr_o = r_wb_addr;
    assign ex_rs_data_o = r_rs_data;
    assign ex_rt_data_o = r_rt_data;
    assign ex_imm_o     = r_imm;
    assign ex_ctrl_o    = r_ctrl;
    assign stall_cnt_o  = r_stall_cnt;
    assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
module tb_id_ex_pipe_stage;

    localparam logic [7:0] LW  = 8'hE4; // regwrite,memtoreg,memread,alusrc
    localparam logic [7:0] ADD = 8'h8A; // regwrite,regdst,aluop=10
    localparam logic [7:0] SW  = 8'h14; // memwrite,alusrc

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [4:0]  id_rs_addr_i = '0;
    logic [4:0]  id_rt_addr_i = '0;
    logic [4:0]  id_rd_addr_i = '0;
    logic        id_uses_rt_i = 1'b0;
    logic [31:0] id_rs_data_i = '0;
    logic [31:0] id_rt_data_i = '0;
    logic [31:0] id_imm_i = '0;
    logic [7:0]  id_ctrl_i = '0;

    logic        ex_valid_o;
    logic [4:0]  ex_rs_addr_o, ex_rt_addr_o, ex_wb_addr_o;
    logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [7:0]  ex_ctrl_o;
    logic        pc_write_o, ifid_write_o;
    logic [15:0] stall_cnt_o, flush_cnt_o;

    logic        s_valid;
    logic [4:0]  s_rs_addr, s_rt_addr, s_wb_addr;
    logic [31:0] s_rs_data, s_rt_data, s_imm;
    logic [7:0]  s_ctrl;
    logic        s_pc_write, s_ifid_write;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    always #5 clk_i = ~clk_i;

    id_ex_pipe_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_uses_rt_i(id_uses_rt_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
        .ex_valid_o(ex_valid_o), .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o),
        .ex_wb_addr_o(ex_wb_addr_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
        .ex_imm_o(ex_imm_o), .ex_ctrl_o(ex_ctrl_o), .pc_write_o(pc_write_o),
        .ifid_write_o(ifid_write_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    id_ex_pipe_stage #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
        .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .id_uses_rt_i(id_uses_rt_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_ctrl_i(id_ctrl_i),
        .ex_valid_o(s_valid), .ex_rs_addr_o(s_rs_addr), .ex_rt_addr_o(s_rt_addr),
        .ex_wb_addr_o(s_wb_addr), .ex_rs_data_o(s_rs_data), .ex_rt_data_o(s_rt_data),
        .ex_imm_o(s_imm), .ex_ctrl_o(s_ctrl), .pc_write_o(s_pc_write),
        .ifid_write_o(s_ifid_write), .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // Directed vector: ID inputs, expected write enable before the edge,
    // expected EX state and counters after it.
    typedef struct {
        logic       st, fl;
        logic [4:0] rs, rt, rd;
        logic       ur;
        logic [7:0] ctrl;
        logic       pcw;
        logic       v;
        logic [4:0] rso, wbo;
        logic [7:0] ctrlo;
        int         sc, fc;
    } vec_t;

    function automatic vec_t mk(logic st, logic fl, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic ur, logic [7:0] ctrl, logic pcw, logic v, logic [4:0] rso,
                                logic [4:0] wbo, logic [7:0] ctrlo, int sc, int fc);
        vec_t r;
        r.st = st; r.fl = fl; r.rs = rs; r.rt = rt; r.rd = rd; r.ur = ur; r.ctrl = ctrl;
        r.pcw = pcw; r.v = v; r.rso = rso; r.wbo = wbo; r.ctrlo = ctrlo; r.sc = sc; r.fc = fc;
        return r;
    endfunction

    vec_t tbl[19];

    // Reference model of the EX-side state, expressed directly from the rules.
    typedef struct {
        logic        v;
        logic [4:0]  rs, rt, wb;
        logic [31:0] rsd, rtd, imm;
        logic [7:0]  ctrl;
    } ex_t;

    ex_t m;
    int  m_sc, m_fc;

    function automatic int sat(int v, int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic ur, input logic [7:0] ctrl);
        mem_stall_i  = st;
        flush_i      = fl;
        id_rs_addr_i = rs;
        id_rt_addr_i = rt;
        id_rd_addr_i = rd;
        id_uses_rt_i = ur;
        id_ctrl_i    = ctrl;
        id_rs_data_i = $urandom;
        id_rt_data_i = $urandom;
        id_imm_i     = $urandom;
    endtask

    task automatic rand_inputs();
        drive(1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              1'($urandom), 8'($urandom));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " valid"}, 64'(ex_valid_o), 64'(0));
        chk({tag, " addrs"}, 64'({ex_rs_addr_o, ex_rt_addr_o, ex_wb_addr_o}), 64'(0));
        chk({tag, " data"},  64'(ex_rs_data_o | ex_rt_data_o | ex_imm_o), 64'(0));
        chk({tag, " ctrl"},  64'(ex_ctrl_o), 64'(0));
        chk({tag, " cnts"},  64'({stall_cnt_o, flush_cnt_o, s_stall_cnt, s_flush_cnt}), 64'(0));
        chk({tag, " pcw"},   64'({pc_write_o, ifid_write_o}), 64'(2'b11));
    endtask

    initial begin
        bit lu, exp_pcw;

        // lw $2 ; add $3,$2,$4 ; lw $0 ; use $0 ; lw $5 ; sw(RS=7,RT=5) ;
        // lw $5 ; sw(RS=5) ; lw $2 ; add+flush ; lw $2 ; add under 3-cycle freeze.
        tbl[0]  = mk(0,0, 1,2,0, 0, LW,  1, 1, 1,2, LW,  0,0);
        tbl[1]  = mk(0,0, 2,4,3, 1, ADD, 0, 0, 0,0, 8'h0,1,0);
        tbl[2]  = mk(0,0, 2,4,3, 1, ADD, 1, 1, 2,3, ADD, 1,0);
        tbl[3]  = mk(0,0, 1,0,0, 0, LW,  1, 1, 1,0, LW,  1,0);
        tbl[4]  = mk(0,0, 0,0,6, 1, ADD, 1, 1, 0,6, ADD, 1,0);
        tbl[5]  = mk(0,0, 1,5,0, 0, LW,  1, 1, 1,5, LW,  1,0);
        tbl[6]  = mk(0,0, 7,5,0, 0, SW,  1, 1, 7,5, SW,  1,0);
        tbl[7]  = mk(0,0, 1,5,0, 0, LW,  1, 1, 1,5, LW,  1,0);
        tbl[8]  = mk(0,0, 5,5,0, 0, SW,  0, 0, 0,0, 8'h0,2,0);
        tbl[9]  = mk(0,0, 5,5,0, 0, SW,  1, 1, 5,5, SW,  2,0);
        tbl[10] = mk(0,0, 1,2,0, 0, LW,  1, 1, 1,2, LW,  2,0);
        tbl[11] = mk(0,1, 2,4,3, 1, ADD, 1, 0, 0,0, 8'h0,2,1);
        tbl[12] = mk(0,0, 2,4,3, 1, ADD, 1, 1, 2,3, ADD, 2,1);
        tbl[13] = mk(0,0, 1,2,0, 0, LW,  1, 1, 1,2, LW,  2,1);
        tbl[14] = mk(1,0, 2,4,3, 1, ADD, 0, 1, 1,2, LW,  2,1);
        tbl[15] = mk(1,0, 2,4,3, 1, ADD, 0, 1, 1,2, LW,  2,1);
        tbl[16] = mk(1,0, 2,4,3, 1, ADD, 0, 1, 1,2, LW,  2,1);
        tbl[17] = mk(0,0, 2,4,3, 1, ADD, 0, 0, 0,0, 8'h0,3,1);
        tbl[18] = mk(0,0, 2,4,3, 1, ADD, 1, 1, 2,3, ADD, 3,1);

        // Reset held with random inputs, including edges under reset.
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            #3;
            check_all_zero($sformatf("reset%0d", i));
            @(posedge clk_i);
            #1;
        end

        // Release reset and run the directed table.
        rst_i = 1'b1;
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].st, tbl[i].fl, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].ur, tbl[i].ctrl);
            #1;
            chk($sformatf("v%0d pc_write", i), 64'(pc_write_o), 64'(tbl[i].pcw));
            chk($sformatf("v%0d ifid_write", i), 64'(ifid_write_o), 64'(tbl[i].pcw));
            tick();
            chk($sformatf("v%0d valid", i), 64'(ex_valid_o), 64'(tbl[i].v));
            chk($sformatf("v%0d rs_addr", i), 64'(ex_rs_addr_o), 64'(tbl[i].rso));
            chk($sformatf("v%0d wb_addr", i), 64'(ex_wb_addr_o), 64'(tbl[i].wbo));
            chk($sformatf("v%0d ctrl", i), 64'(ex_ctrl_o), 64'(tbl[i].ctrlo));
            chk($sformatf("v%0d stall_cnt", i), 64'(stall_cnt_o), 64'(tbl[i].sc));
            chk($sformatf("v%0d flush_cnt", i), 64'(flush_cnt_o), 64'(tbl[i].fc));
            chk($sformatf("v%0d stall_cnt2", i), 64'(s_stall_cnt), 64'(sat(tbl[i].sc, 3)));
        end

        // Two more load-use stalls: narrow counter must stay at 3.
        for (int k = 0; k < 2; k++) begin
            drive(0,0, 1,2,0, 0, LW); tick();
            drive(0,0, 2,4,3, 1, ADD); tick();
            tick();
        end
        chk("sat stall_cnt2", 64'(s_stall_cnt), 64'(3));
        chk("sat stall_cnt",  64'(stall_cnt_o), 64'(5));

        // Reset asserted in the middle of a load-use stall drops the stall.
        drive(0,0, 1,2,0, 0, LW); tick();
        drive(0,0, 2,4,3, 1, ADD);
        #1;
        chk("midrst pre pcw", 64'(pc_write_o), 64'(0));
        rst_i = 1'b0;
        #1;
        check_all_zero("midrst");
        tick();
        rst_i = 1'b1;
        #1;
        chk("midrst rel pcw", 64'(pc_write_o), 64'(1));
        tick();
        chk("midrst capture valid", 64'(ex_valid_o), 64'(1));
        chk("midrst capture rs", 64'(ex_rs_addr_o), 64'(2));
        chk("midrst stall_cnt", 64'(stall_cnt_o), 64'(0));

        // Randomised run against the reference model.
        rst_i = 1'b0;
        #2;
        rst_i = 1'b1;
        m = '{default: '0};
        m_sc = 0;
        m_fc = 0;
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                  1'($urandom), 8'($urandom) | ($urandom_range(0, 1) ? 8'h20 : 8'h00));
            lu = m.v && m.ctrl[5] && (m.rt != 0) &&
                 ((m.rt == id_rs_addr_i) || (id_uses_rt_i && (m.rt == id_rt_addr_i)));
            exp_pcw = !mem_stall_i && (flush_i || !lu);
            #1;
            chk("rnd pc_write", 64'(pc_write_o), 64'(exp_pcw));
            chk("rnd ifid_write", 64'(ifid_write_o), 64'(exp_pcw));
            if (mem_stall_i) begin
                // frozen
            end else if (flush_i) begin
                m = '{default: '0};
                m_fc++;
            end else if (lu) begin
                m = '{default: '0};
                m_sc++;
            end else begin
                m.v = 1'b1;
                m.rs = id_rs_addr_i;
                m.rt = id_rt_addr_i;
                m.wb = id_ctrl_i[3] ? id_rd_addr_i : id_rt_addr_i;
                m.rsd = id_rs_data_i;
                m.rtd = id_rt_data_i;
                m.imm = id_imm_i;
                m.ctrl = id_ctrl_i;
            end
            tick();
            chk("rnd valid", 64'(ex_valid_o), 64'(m.v));
            chk("rnd addrs", 64'({ex_rs_addr_o, ex_rt_addr_o, ex_wb_addr_o}), 64'({m.rs, m.rt, m.wb}));
            chk("rnd rs_data", 64'(ex_rs_data_o), 64'(m.rsd));
            chk("rnd rt_data", 64'(ex_rt_data_o), 64'(m.rtd));
            chk("rnd imm", 64'(ex_imm_o), 64'(m.imm));
            chk("rnd ctrl", 64'(ex_ctrl_o), 64'(m.ctrl));
            chk("rnd stall_cnt", 64'(stall_cnt_o), 64'(sat(m_sc, 65535)));
            chk("rnd flush_cnt", 64'(flush_cnt_o), 64'(sat(m_fc, 65535)));
            chk("rnd cnt2", 64'({s_stall_cnt, s_flush_cnt}), 64'({2'(sat(m_sc, 3)), 2'(sat(m_fc, 3))}));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
